// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin arbitration, packet locking and credit tracking.
// Optional 32-bit statistics counters are enabled by defining OUTPUT_PORT_ALLOC_STATS_EN.
module output_port_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 256,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int SEL_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   turn_disable,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic [SEL_WIDTH-1:0]    sel,
  output logic                    send_out,
  output logic                    locked,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
`ifdef OUTPUT_PORT_ALLOC_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic [31:0]             flit_count,
  output logic [31:0]             stall_count
`endif
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [CREDIT_WIDTH-1:0] CREDITS_FULL = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [SEL_WIDTH-1:0]    LAST_INPUT   = SEL_WIDTH'(NUM_INPUTS - 1);
  localparam logic [NUM_INPUTS-1:0]   ONE_HOT_0    = NUM_INPUTS'(1);

  state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0]    owner_q, owner_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic                    credit_err_q, credit_err_d;

  logic [NUM_INPUTS-1:0]   eligible;
  logic                    any_eligible;
  logic [SEL_WIDTH-1:0]    winner;
  logic [SEL_WIDTH-1:0]    xfer_idx;
  logic                    have_credit;

  assign eligible    = req & ~turn_disable;
  assign have_credit = (credits_q != '0);
  assign credits     = credits_q;
  assign credit_err  = credit_err_q;

  // Round-robin search: first eligible input at or after rr_ptr, wrapping.
  always_comb begin
    int                   idx;
    logic [SEL_WIDTH-1:0] idx_sel;
    any_eligible = 1'b0;
    winner       = '0;
    idx          = 0;
    idx_sel      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx     = (int'(rr_ptr_q) + k) % NUM_INPUTS;
      idx_sel = SEL_WIDTH'(idx);
      if (!any_eligible && eligible[idx_sel]) begin
        any_eligible = 1'b1;
        winner       = idx_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      sel_q        <= '0;
      credits_q    <= CREDITS_FULL;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      sel_q        <= sel_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  // While locked, only the owner is served and turn_disable no longer applies.
  always_comb begin
    grant    = '0;
    send_out = 1'b0;
    sel      = sel_q;
    locked   = (state_q == LOCKED);
    xfer_idx = winner;
    if (state_q == LOCKED) begin
      sel      = owner_q;
      xfer_idx = owner_q;
      if (req[owner_q] && have_credit) begin
        grant    = ONE_HOT_0 << owner_q;
        send_out = 1'b1;
      end
    end else if (any_eligible && have_credit) begin
      grant    = ONE_HOT_0 << winner;
      sel      = winner;
      send_out = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel;
    if (send_out) begin
      if (req_is_tail[xfer_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = (xfer_idx == LAST_INPUT) ? '0 : xfer_idx + 1'b1;
      end else begin
        state_d = LOCKED;
        owner_d = xfer_idx;
      end
    end
  end

  // A credit returned while already full is dropped and flagged until reset.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (send_out && !credit_in) begin
      credits_d = credits_q - 1'b1;
    end else if (!send_out && credit_in) begin
      if (credits_q == CREDITS_FULL) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

`ifdef OUTPUT_PORT_ALLOC_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] flit_count_q, flit_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        stalled;

  assign stalled     = !have_credit && ((state_q == LOCKED) ? req[owner_q] : any_eligible);
  assign pkt_count   = pkt_count_q;
  assign flit_count  = flit_count_q;
  assign stall_count = stall_count_q;

  always_comb begin
    pkt_count_d   = pkt_count_q + {31'd0, (send_out && req_is_tail[xfer_idx])};
    flit_count_d  = flit_count_q + {31'd0, send_out};
    stall_count_d = stall_count_q + {31'd0, stalled};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q   <= '0;
      flit_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      flit_count_q  <= flit_count_d;
      stall_count_q <= stall_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: directed scenarios plus randomized traffic
// checked against a packet-level reference model; instance 0 uses depth 256, instance 1 depth 2.
module tb_output_port_allocator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] tail = '0;
  logic [4:0] tdis = '0;
  logic       cin = 1'b0;

  logic [4:0] grant_o [2];
  logic [2:0] sel_o   [2];
  logic       send_o  [2];
  logic       lock_o  [2];
  logic       err_o   [2];
  logic [8:0] cred_o  [2];
  logic [8:0] cred_a;
  logic [1:0] cred_b;

  int checks = 0;
  int failures = 0;

  // Reference model state, per instance
  int m_depth [2] = '{256, 2};
  int m_cred  [2];
  bit m_lock  [2];
  int m_owner [2];
  int m_rr    [2];
  int m_sel   [2];
  bit m_err   [2];
  int m_pkt   [2];
  int m_flit  [2];
  int m_stall [2];

  // Expected outputs for the current cycle
  logic [4:0] e_grant  [2];
  bit         e_send   [2];
  bit         e_locked [2];
  bit         e_err    [2];
  int         e_sel    [2];
  int         e_cred   [2];

`ifdef OUTPUT_PORT_ALLOC_STATS_EN
  logic [31:0] pkt_o [2];
  logic [31:0] flit_o [2];
  logic [31:0] stall_o [2];
`endif

  always #5 clk = ~clk;

  assign cred_o[0] = cred_a;
  assign cred_o[1] = {7'd0, cred_b};

  output_port_allocator #(.NUM_INPUTS(5), .FLIT_BUFFER_DEPTH(256)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .req_is_tail(tail), .turn_disable(tdis),
    .credit_in(cin), .grant(grant_o[0]), .sel(sel_o[0]), .send_out(send_o[0]),
    .locked(lock_o[0]), .credits(cred_a), .credit_err(err_o[0])
`ifdef OUTPUT_PORT_ALLOC_STATS_EN
    , .pkt_count(pkt_o[0]), .flit_count(flit_o[0]), .stall_count(stall_o[0])
`endif
  );

  output_port_allocator #(.NUM_INPUTS(5), .FLIT_BUFFER_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .req_is_tail(tail), .turn_disable(tdis),
    .credit_in(cin), .grant(grant_o[1]), .sel(sel_o[1]), .send_out(send_o[1]),
    .locked(lock_o[1]), .credits(cred_b), .credit_err(err_o[1])
`ifdef OUTPUT_PORT_ALLOC_STATS_EN
    , .pkt_count(pkt_o[1]), .flit_count(flit_o[1]), .stall_count(stall_o[1])
`endif
  );

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_cred[n] = m_depth[n]; m_lock[n] = 0; m_owner[n] = 0; m_rr[n] = 0;
      m_sel[n] = 0; m_err[n] = 0; m_pkt[n] = 0; m_flit[n] = 0; m_stall[n] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; tail = '0; tdis = '0; cin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, derive expected outputs from the model, advance the model.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic [4:0] d, input logic c);
    @(negedge clk);
    req = r; tail = t; tdis = d; cin = c;
    #1;
    for (int n = 0; n < 2; n++) begin
      int win;
      int first;
      win = -1;
      first = -1;
      if (m_cred[n] != 0) begin
        if (m_lock[n]) begin
          if (r[m_owner[n]]) win = m_owner[n];
        end else begin
          // lowest eligible index >= rr pointer, else the lowest eligible overall
          for (int i = 0; i < 5; i++) begin
            if (r[i] && !d[i]) begin
              if (first < 0) first = i;
              if (win < 0 && i >= m_rr[n]) win = i;
            end
          end
          if (win < 0) win = first;
        end
      end
      e_grant[n]  = (win >= 0) ? (5'b00001 << win) : 5'b00000;
      e_send[n]   = (win >= 0);
      e_locked[n] = m_lock[n];
      e_cred[n]   = m_cred[n];
      e_err[n]    = m_err[n];
      e_sel[n]    = m_lock[n] ? m_owner[n] : ((win >= 0) ? win : m_sel[n]);
      if (m_cred[n] == 0 && (m_lock[n] ? r[m_owner[n]] : ((r & ~d) != 0))) m_stall[n]++;
      if (win >= 0) begin
        m_flit[n]++;
        m_sel[n] = win;
        if (t[win]) begin
          m_pkt[n]++;
          m_lock[n] = 0;
          m_rr[n] = (win + 1) % 5;
        end else begin
          m_lock[n] = 1;
          m_owner[n] = win;
        end
      end
      if (c && !e_send[n] && m_cred[n] == m_depth[n]) m_err[n] = 1;
      else m_cred[n] = m_cred[n] - int'(e_send[n]) + int'(c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(5'b00000, 5'b00000, 5'b00000, 1'b0);
      checks++; if (grant_o[0] !== 5'b00000) begin failures++; $display("FAIL reset_grant actual=%b required=00000", grant_o[0]); end
      checks++; if (send_o[0] !== 1'b0) begin failures++; $display("FAIL reset_send actual=%b required=0", send_o[0]); end
      checks++; if (cred_a !== 9'd256) begin failures++; $display("FAIL reset_credits actual=%0d required=256", cred_a); end
      checks++; if (lock_o[0] !== 1'b0) begin failures++; $display("FAIL reset_locked actual=%b required=0", lock_o[0]); end
      checks++; if (err_o[0] !== 1'b0) begin failures++; $display("FAIL reset_credit_err actual=%b required=0", err_o[0]); end
      checks++; if (sel_o[0] !== 3'd0) begin failures++; $display("FAIL reset_sel actual=%0d required=0", sel_o[0]); end
    end
  endtask

  task automatic test_single_flit_contention();
    logic [4:0] exp_g [3] = '{5'b00010, 5'b00100, 5'b10000};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(5'b10110, 5'b11111, 5'b00000, 1'b0);
      checks++; if (grant_o[0] !== exp_g[k]) begin failures++; $display("FAIL contention_grant[%0d] actual=%b required=%b", k, grant_o[0], exp_g[k]); end
      checks++; if (int'(cred_a) !== 256 - k) begin failures++; $display("FAIL contention_credits[%0d] actual=%0d required=%0d", k, cred_a, 256 - k); end
    end
    step(5'b11111, 5'b11111, 5'b00000, 1'b0);
    checks++; if (cred_a !== 9'd253) begin failures++; $display("FAIL contention_final_credits actual=%0d required=253", cred_a); end
    checks++; if (grant_o[0] !== 5'b00001) begin failures++; $display("FAIL contention_rr_wrap actual=%b required=00001", grant_o[0]); end
  endtask

  task automatic test_wormhole_lock();
    logic [4:0] r_s [6] = '{5'b01001, 5'b00001, 5'b01001, 5'b01001, 5'b01001, 5'b00001};
    logic [4:0] t_s [6] = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b01001, 5'b00001};
    logic [4:0] g_x [6] = '{5'b01000, 5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b00001};
    bit         l_x [6] = '{0, 1, 1, 1, 1, 0};
    do_reset();
    step(5'b00010, 5'b00010, 5'b00000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(r_s[k], t_s[k], 5'b00000, 1'b0);
      checks++; if (grant_o[0] !== g_x[k]) begin failures++; $display("FAIL wormhole_grant[%0d] actual=%b required=%b", k, grant_o[0], g_x[k]); end
      checks++; if (lock_o[0] !== l_x[k]) begin failures++; $display("FAIL wormhole_locked[%0d] actual=%b required=%b", k, lock_o[0], l_x[k]); end
      if (k >= 1 && k <= 4) begin
        checks++; if (sel_o[0] !== 3'd3) begin failures++; $display("FAIL wormhole_sel[%0d] actual=%0d required=3", k, sel_o[0]); end
      end
    end
  endtask

  task automatic test_credit_exhaustion();
    logic [4:0] r_s [6] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    logic [4:0] t_s [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
    logic       c_s [6] = '{0, 0, 0, 1, 0, 0};
    logic [4:0] g_x [6] = '{5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 5'b00000};
    int         c_x [6] = '{2, 1, 0, 0, 1, 0};
    bit         l_x [6] = '{0, 1, 1, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(r_s[k], t_s[k], 5'b00000, c_s[k]);
      checks++; if (grant_o[1] !== g_x[k]) begin failures++; $display("FAIL exhaust_grant[%0d] actual=%b required=%b", k, grant_o[1], g_x[k]); end
      checks++; if (int'(cred_b) !== c_x[k]) begin failures++; $display("FAIL exhaust_credits[%0d] actual=%0d required=%0d", k, cred_b, c_x[k]); end
      checks++; if (lock_o[1] !== l_x[k]) begin failures++; $display("FAIL exhaust_locked[%0d] actual=%b required=%b", k, lock_o[1], l_x[k]); end
      checks++; if (send_o[1] !== (g_x[k] != 5'b0)) begin failures++; $display("FAIL exhaust_send[%0d] actual=%b required=%b", k, send_o[1], (g_x[k] != 5'b0)); end
    end
  endtask

  task automatic test_turn_disable();
    logic [4:0] t_s [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00000};
    logic [4:0] d_s [6] = '{5'b00010, 5'b00010, 5'b00000, 5'b00010, 5'b00010, 5'b00010};
    logic [4:0] g_x [6] = '{5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
    bit         l_x [6] = '{0, 0, 0, 1, 1, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(5'b00010, t_s[k], d_s[k], 1'b0);
      checks++; if (grant_o[0] !== g_x[k]) begin failures++; $display("FAIL turn_grant[%0d] actual=%b required=%b", k, grant_o[0], g_x[k]); end
      checks++; if (lock_o[0] !== l_x[k]) begin failures++; $display("FAIL turn_locked[%0d] actual=%b required=%b", k, lock_o[0], l_x[k]); end
    end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    step(5'b00000, 5'b00000, 5'b00000, 1'b1);
    checks++; if (err_o[0] !== 1'b0) begin failures++; $display("FAIL overflow_err_before actual=%b required=0", err_o[0]); end
    step(5'b00000, 5'b00000, 5'b00000, 1'b0);
    checks++; if (cred_a !== 9'd256) begin failures++; $display("FAIL overflow_credits actual=%0d required=256", cred_a); end
    checks++; if (err_o[0] !== 1'b1) begin failures++; $display("FAIL overflow_err_set actual=%b required=1", err_o[0]); end
    checks++; if (err_o[1] !== 1'b1) begin failures++; $display("FAIL overflow_err_set_b actual=%b required=1", err_o[1]); end
    for (int k = 0; k < 4; k++) begin
      step(5'b00001, 5'b00001, 5'b00000, 1'b0);
      checks++; if (err_o[0] !== 1'b1) begin failures++; $display("FAIL overflow_err_sticky[%0d] actual=%b required=1", k, err_o[0]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(5'($urandom), 5'($urandom & $urandom), 5'($urandom & $urandom & $urandom), ($urandom_range(0, 3) == 0));
      for (int n = 0; n < 2; n++) begin
        checks++; if (grant_o[n] !== e_grant[n]) begin failures++; $display("FAIL rand_grant inst%0d cyc%0d actual=%b required=%b", n, k, grant_o[n], e_grant[n]); end
        checks++; if (send_o[n] !== e_send[n]) begin failures++; $display("FAIL rand_send inst%0d cyc%0d actual=%b required=%b", n, k, send_o[n], e_send[n]); end
        checks++; if (int'(sel_o[n]) !== e_sel[n]) begin failures++; $display("FAIL rand_sel inst%0d cyc%0d actual=%0d required=%0d", n, k, sel_o[n], e_sel[n]); end
        checks++; if (lock_o[n] !== e_locked[n]) begin failures++; $display("FAIL rand_locked inst%0d cyc%0d actual=%b required=%b", n, k, lock_o[n], e_locked[n]); end
        checks++; if (int'(cred_o[n]) !== e_cred[n]) begin failures++; $display("FAIL rand_credits inst%0d cyc%0d actual=%0d required=%0d", n, k, cred_o[n], e_cred[n]); end
        checks++; if (err_o[n] !== e_err[n]) begin failures++; $display("FAIL rand_credit_err inst%0d cyc%0d actual=%b required=%b", n, k, err_o[n], e_err[n]); end
      end
    end
  endtask

  task automatic test_stats();
`ifdef OUTPUT_PORT_ALLOC_STATS_EN
    logic [4:0] r_s [9] = '{5'b00001, 5'b00010, 5'b00010, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
    logic [4:0] t_s [9] = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000};
    do_reset();
    for (int k = 0; k < 9; k++) step(r_s[k], t_s[k], 5'b00000, (k >= 5));
    checks++; if (pkt_o[0] !== 32'd3) begin failures++; $display("FAIL stats_pkt_count actual=%0d required=3", pkt_o[0]); end
    checks++; if (flit_o[0] !== 32'd7) begin failures++; $display("FAIL stats_flit_count actual=%0d required=7", flit_o[0]); end
    for (int n = 0; n < 2; n++) begin
      checks++; if (int'(pkt_o[n]) !== m_pkt[n]) begin failures++; $display("FAIL stats_pkt_model inst%0d actual=%0d required=%0d", n, pkt_o[n], m_pkt[n]); end
      checks++; if (int'(flit_o[n]) !== m_flit[n]) begin failures++; $display("FAIL stats_flit_model inst%0d actual=%0d required=%0d", n, flit_o[n], m_flit[n]); end
      checks++; if (int'(stall_o[n]) !== m_stall[n]) begin failures++; $display("FAIL stats_stall_model inst%0d actual=%0d required=%0d", n, stall_o[n], m_stall[n]); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_flit_contention();
    test_wormhole_lock();
    test_credit_exhaustion();
    test_turn_disable();
    test_credit_overflow();
    test_random();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port wormhole switch allocator for the NoC router; one instance per router output (NUM_PORTS instances per router).
- Arbitrates round-robin among input-port requests and locks the output to the winner until its tail flit passes.
- Tracks downstream buffer credits, and drives the crossbar select and the output send strobe.
- Honours the per-input turn-disable mask.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports (port 0 = local injection).
- FLIT_BUFFER_DEPTH, 256, downstream input-buffer depth; initial and maximum credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width.
- SEL_WIDTH, $clog2(NUM_INPUTS), width of the binary select.

Ports:
- clk  input  1  NoC clock; all state on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_INPUTS  input i has a flit at its buffer head routed to this output.
- req_is_tail  input  NUM_INPUTS  head flit of input i is a tail flit.
- turn_disable  input  NUM_INPUTS  1 = input i may not start packets on this output (DISABLE_TURNS column).
- credit_in  input  1  one downstream buffer slot freed.
- grant  output  NUM_INPUTS  one-hot: input whose head flit is forwarded this cycle (pop strobe).
- sel  output  SEL_WIDTH  crossbar select (binary index of current or held owner).
- send_out  output  1  flit forwarded downstream this cycle; equals OR of grant.
- locked  output  1  output is mid-packet.
- credits  output  CREDIT_WIDTH  current credit count.
- credit_err  output  1  sticky: credit_in received while credits == FLIT_BUFFER_DEPTH.

Behaviour:
- Reset (async assert, sync release) sets the following:
  - state=IDLE, rr_ptr=0, owner=0, credits=FLIT_BUFFER_DEPTH, credit_err=0.
  - grant=0, send_out=0, sel=0, locked=0.
- Eligible request in IDLE: req[i] & ~turn_disable[i]. turn_disable is ignored while LOCKED; a packet is never cut.
- Flit transfer requires credits != 0. With credits == 0, grant=0 and send_out=0, and no state change except credit return.
- IDLE state:
  - If any input is eligible and credits != 0, the winner is the first eligible index at or after rr_ptr, wrapping modulo NUM_INPUTS.
  - grant[winner]=1 combinationally in the same cycle, sel=winner, send_out=1.
  - If req_is_tail[winner]=1 (single-flit packet): stay in IDLE, and rr_ptr <= (winner+1) mod NUM_INPUTS.
  - Otherwise: go to LOCKED and set owner <= winner.
  - With no eligible request, sel holds its last value.
- LOCKED state:
  - sel=owner and locked=1.
  - grant[owner] = req[owner] & (credits != 0). Requests from other inputs are ignored.
  - Transfer with req_is_tail[owner]=1: go to IDLE next cycle, and rr_ptr <= (owner+1) mod NUM_INPUTS.
  - A bubble (req[owner]=0) holds the lock with no transfer.
- Latency: zero cycles from request to grant (combinational). Minimum packet of N flits occupies the output for N cycles. The next packet can be granted on the cycle after the tail.
- Credit counter: credits_next = credits − send_out + credit_in.
  - Simultaneous send and credit leave the count unchanged.
  - At credits == FLIT_BUFFER_DEPTH, a credit_in without a send saturates the count and sets credit_err.
  - Underflow cannot occur because send is gated by credits != 0.
- Arithmetic: rr_ptr wraps from NUM_INPUTS−1 to 0. For non-power-of-two NUM_INPUTS, pointer values ≥ NUM_INPUTS are unreachable.
- Reset asserted mid-packet: the lock is dropped and credits return to full. The upstream is expected to be reset in the same domain.

Optional Feature:
- Macro OUTPUT_PORT_ALLOC_STATS_EN.
- When defined, adds the following 32-bit wrapping counters, all reset to 0:
  - output pkt_count: increments on every tail transfer.
  - output flit_count: increments on every send_out.
  - output stall_count: increments on cycles with an eligible or owner request but credits == 0.
- When undefined, these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then req=5'b00000 for 4 cycles -> grant=0, send_out=0, credits=256, locked=0, credit_err=0.
- Single-flit contention: req=5'b10110 all tails, hold for 3 cycles, no credit return -> grants in order input 1, 2, 4 (one per cycle); credits 255, 254, 253; rr_ptr ends at 0.
- Wormhole lock: input 3 sends a 4-flit packet (tail on 4th) while input 0 requests throughout; bubble on flit 2 -> grant to input 3 on 4 of 5 cycles, no grant on the bubble cycle, locked high until the tail, input 0 granted on the cycle after the tail.
- Credit exhaustion: FLIT_BUFFER_DEPTH=2, a 3-flit packet from input 2 -> 2 flits sent, credits=0, stall with locked=1; one credit_in -> credits=1 next cycle, and the tail is sent the following cycle.
- Turn disable: turn_disable=5'b00010, req=5'b00010 -> no grant. Then input 1 holds the lock when turn_disable rises mid-packet -> transfers continue to the tail.
- Credit overflow: credits=256 with credit_in=1 and no send -> credits stays 256, credit_err=1 and stays 1 until reset. With OUTPUT_PORT_ALLOC_STATS_EN: 3 packets totalling 7 flits -> pkt_count=3, flit_count=7.
